// File: rtl/uart_pkg.sv
// uart_pkg: register map, status bit positions and receiver state type shared by the UART blocks
package uart_pkg;
   localparam int ADDR_DATA   = 0;
   localparam int ADDR_STATUS = 1;
   localparam int ST_VALID    = 0;
   localparam int ST_OVR      = 1;
   localparam int ST_FERR     = 2;
   localparam int ST_PERR     = 3;
   localparam int ST_BUSY     = 4;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchronizer for an asynchronous input, reset to 1 (idle line level)
module uart_sync #(
   parameter int stages = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [stages-1:0] sr;
   always_ff @(posedge clk or posedge rst)
      if (rst) sr <= '1;
      else sr <= {sr[stages-2:0], d};
   assign q = sr[stages-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with a one-byte holding register and an Avalon-MM data/status interface
module uart_rx
   import uart_pkg::*;
#(
   parameter int    AAW      = 1,
   parameter int    ADW      = 32,
   localparam int   ABW      = ADW/8,
   parameter int    BYTESIZE = 8,
   parameter string PARITY   = "NONE",
   parameter int    STOPSIZE = 1,
   parameter int    N_BIT    = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           avalon_read,
   input  logic           avalon_write,
   input  logic [AAW-1:0] avalon_address,
   input  logic [ABW-1:0] avalon_byteenable,
   input  logic [ADW-1:0] avalon_writedata,
   output logic [ADW-1:0] avalon_readdata,
   output logic           avalon_waitrequest,
   input  logic           uart_rxd
);
   localparam int CW      = $clog2(N_BIT);
   localparam bit HAS_PAR = (PARITY != "NONE");
   localparam bit PAR_ODD = (PARITY == "ODD");
   rx_state_t state;
   logic [CW-1:0] cnt;
   logic [2:0] bit_cnt;
   logic [BYTESIZE-1:0] shreg, hold;
   logic rxd_s, rxd_q, tick, last_stop, load, perr_set, ferr_set, par_exp;
   logic rx_valid, ovr, perr, ferr, is_data, is_status, pop, wc;
   logic [ADW-1:0] status;
   logic unused_ok;
   uart_sync #(.stages(2)) u_sync (.clk(clk), .rst(rst), .d(uart_rxd), .q(rxd_s));
   assign tick      = (cnt == '0);
   assign last_stop = (bit_cnt == 3'(STOPSIZE-1));
   assign par_exp   = PAR_ODD ? ~^shreg : ^shreg;
   assign load      = (state == RX_STOP) & tick & last_stop;
   assign perr_set  = (state == RX_PARITY) & tick & (rxd_s != par_exp);
   assign ferr_set  = (state == RX_STOP) & tick & ~rxd_s;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= RX_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         rxd_q   <= 1'b1;
      end else begin
         rxd_q <= rxd_s;
         cnt   <= tick ? CW'(N_BIT-1) : cnt - 1'b1;
         case (state)
            RX_IDLE:
               if (rxd_q & ~rxd_s) begin
                  state <= RX_START;
                  cnt   <= CW'(N_BIT/2-1);
               end
            RX_START:
               if (tick) begin
                  state   <= rxd_s ? RX_IDLE : RX_DATA;
                  bit_cnt <= '0;
               end
            RX_DATA:
               if (tick) begin
                  shreg   <= {rxd_s, shreg[BYTESIZE-1:1]};
                  bit_cnt <= (bit_cnt == 3'(BYTESIZE-1)) ? '0 : bit_cnt + 1'b1;
                  if (bit_cnt == 3'(BYTESIZE-1)) state <= HAS_PAR ? RX_PARITY : RX_STOP;
               end
            RX_PARITY:
               if (tick) state <= RX_STOP;
            RX_STOP:
               if (tick) begin
                  bit_cnt <= last_stop ? '0 : bit_cnt + 1'b1;
                  if (last_stop) state <= RX_IDLE;
               end
            default: state <= RX_IDLE;
         endcase
      end
   assign is_data            = (avalon_address == AAW'(ADDR_DATA));
   assign is_status          = (avalon_address == AAW'(ADDR_STATUS));
   assign pop                = avalon_read & is_data & rx_valid;
   assign wc                 = avalon_write & is_status & avalon_byteenable[0];
   assign avalon_waitrequest = avalon_read & is_data & ~rx_valid;
   // a load coinciding with a pop keeps rx_valid set and is not an overrun
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         hold     <= '0;
         rx_valid <= 1'b0;
         ovr      <= 1'b0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
      end else begin
         if (load) hold <= shreg;
         rx_valid <= load | (rx_valid & ~pop);
         ovr      <= (ovr & ~(wc & avalon_writedata[ST_OVR])) | (load & rx_valid & ~pop);
         perr     <= (perr & ~(wc & avalon_writedata[ST_PERR])) | perr_set;
         ferr     <= (ferr & ~(wc & avalon_writedata[ST_FERR])) | ferr_set;
      end
   always_comb begin
      status            = '0;
      status[ST_VALID]  = rx_valid;
      status[ST_OVR]    = ovr;
      status[ST_FERR]   = ferr;
      status[ST_PERR]   = perr;
      status[ST_BUSY]   = (state != RX_IDLE);
   end
   assign avalon_readdata = ~avalon_read ? '0 : is_data ? ADW'(hold) : is_status ? status : '0;
   assign unused_ok = ^{avalon_byteenable, avalon_writedata};
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a frame-level model of the receiver's register view
module tb_uart_rx;
   localparam int NB = 4;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic a_read = 0, a_write = 0, a_wait, a_rxd = 1;
   logic [0:0] a_addr = 0;
   logic [3:0] a_be = 0;
   logic [31:0] a_wdata = 0, a_rdata;
   logic e_read = 0, e_write = 0, e_wait, e_rxd = 1;
   logic [0:0] e_addr = 0;
   logic [3:0] e_be = 0;
   logic [31:0] e_wdata = 0, e_rdata;
   int checks = 0, errors = 0;
   logic m_valid = 0, m_ovr = 0, m_ferr = 0, m_perr = 0;
   logic [7:0] m_data = 0;
   bit abort = 0;
   uart_rx #(.N_BIT(NB)) dut (
      .clk(clk), .rst(rst), .avalon_read(a_read), .avalon_write(a_write),
      .avalon_address(a_addr), .avalon_byteenable(a_be), .avalon_writedata(a_wdata),
      .avalon_readdata(a_rdata), .avalon_waitrequest(a_wait), .uart_rxd(a_rxd));
   uart_rx #(.N_BIT(NB), .PARITY("EVEN")) dut_e (
      .clk(clk), .rst(rst), .avalon_read(e_read), .avalon_write(e_write),
      .avalon_address(e_addr), .avalon_byteenable(e_be), .avalon_writedata(e_wdata),
      .avalon_readdata(e_rdata), .avalon_waitrequest(e_wait), .uart_rxd(e_rxd));
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   function automatic logic [31:0] exp_status();
      return 32'({m_perr, m_ferr, m_ovr, m_valid});
   endfunction
   always @(negedge clk)
      if (!rst) begin
         if (!a_read) begin
            chk("idle_rdata", a_rdata, 0);
            chk("idle_wait", 32'(a_wait), 0);
         end else if (!a_wait) begin
            if (a_addr == 0) begin
               chk("model_data", a_rdata, {24'b0, m_data});
               m_valid = 0;
            end else chk("model_status", a_rdata & ~32'h10, exp_status());
         end
      end
   task automatic send(input bit ev, input logic [7:0] b, input logic stopv, input bit has_par, input logic parv);
      logic [10:0] fr;
      int nb;
      fr = has_par ? {stopv, parv, b, 1'b0} : {1'b1, stopv, b, 1'b0};
      nb = has_par ? 11 : 10;
      @(posedge clk); #1;
      for (int i = 0; i < nb; i++) begin
         if (i == nb-1 && !ev) begin
            if (m_valid) m_ovr = 1;
            m_valid = 1;
            m_data = b;
            if (!stopv) m_ferr = 1;
         end
         if (ev) e_rxd = fr[i]; else a_rxd = fr[i];
         for (int c = 0; c < NB; c++) begin
            @(posedge clk); #1;
            if (abort) return;
         end
      end
      if (ev) e_rxd = 1; else a_rxd = 1;
      repeat (2*NB) @(posedge clk);
      #1;
   endtask
   task automatic rd(input bit ev, input logic adr, output logic [31:0] d, output int n);
      n = 0;
      @(posedge clk); #1;
      if (ev) begin e_read = 1; e_addr = adr; end
      else begin a_read = 1; a_addr = adr; end
      forever begin
         @(negedge clk);
         if (!(ev ? e_wait : a_wait)) break;
         n++;
         if (n > 2000) begin
            checks++;
            errors++;
            $display("FAIL rd_timeout: waitrequest still 1 after %0d cycles", n);
            break;
         end
      end
      d = ev ? e_rdata : a_rdata;
      @(posedge clk); #1;
      a_read = 0;
      e_read = 0;
   endtask
   task automatic wr(input bit ev, input logic adr, input logic [3:0] be, input logic [31:0] d);
      @(posedge clk); #1;
      if (ev) begin e_write = 1; e_addr = adr; e_be = be; e_wdata = d; end
      else begin a_write = 1; a_addr = adr; a_be = be; a_wdata = d; end
      @(posedge clk); #1;
      a_write = 0;
      e_write = 0;
      if (!ev && adr && be[0]) begin
         if (d[1]) m_ovr = 0;
         if (d[2]) m_ferr = 0;
         if (d[3]) m_perr = 0;
      end
   endtask
   logic [31:0] d;
   int n;
   bit saw;
   initial begin
      a_read = 1; a_addr = 0;
      #2;
      chk("rst_wait", 32'(a_wait), 1);
      chk("rst_data", a_rdata, 0);
      a_addr = 1;
      #1;
      chk("rst_status", a_rdata, 0);
      a_read = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      send(0, 8'h48, 1, 0, 0);
      rd(0, 0, d, n); chk("h_data", d, 32'h48);
      rd(0, 1, d, n); chk("h_status", d, 32'h0);
      fork
         rd(0, 0, d, n);
         send(0, 8'h65, 1, 0, 0);
         begin repeat (3) @(negedge clk); chk("pend_wait", 32'(a_wait), 1); end
      join
      chk("e_data", d, 32'h65);
      chk("e_wait_len", 32'(n >= 9*NB && n <= 11*NB), 1);
      send(0, 8'h6C, 1, 0, 0);
      send(0, 8'h6F, 1, 0, 0);
      rd(0, 1, d, n); chk("ovr_status", d, 32'h3);
      rd(0, 0, d, n); chk("ovr_data", d, 32'h6F);
      wr(0, 0, 4'hF, 32'h2);
      wr(0, 1, 4'h0, 32'h2);
      rd(0, 1, d, n); chk("w1c_ignored", d, 32'h2);
      wr(0, 1, 4'h1, 32'h2);
      rd(0, 1, d, n); chk("w1c_status", d, 32'h0);
      send(0, 8'h33, 0, 0, 0);
      rd(0, 1, d, n); chk("ferr_status", d, 32'h5);
      rd(0, 0, d, n); chk("ferr_data", d, 32'h33);
      wr(0, 1, 4'h1, 32'h4);
      @(posedge clk); #1;
      a_read = 1; a_addr = 1; a_rxd = 0;
      saw = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (a_rdata[4]) saw = 1;
         if (i == 1) begin @(posedge clk); #1; a_rxd = 1; end
      end
      @(posedge clk); #1;
      a_read = 0;
      chk("glitch_busy_seen", 32'(saw), 1);
      rd(0, 1, d, n); chk("glitch_status", d, 32'h0);
      fork
         send(0, 8'h21, 1, 0, 0);
         begin
            repeat (4*NB) @(posedge clk);
            #2;
            rst = 1; abort = 1; a_rxd = 1; a_read = 1; a_addr = 0;
            @(negedge clk);
            chk("midrst_wait", 32'(a_wait), 1);
            chk("midrst_data", a_rdata, 0);
            a_read = 0;
            @(posedge clk); #1;
            rst = 0;
            m_valid = 0; m_ovr = 0; m_ferr = 0; m_perr = 0; m_data = 0;
         end
      join
      abort = 0;
      repeat (4*NB) @(posedge clk);
      rd(0, 1, d, n); chk("midrst_status", d, 32'h0);
      send(0, 8'h21, 1, 0, 0);
      rd(0, 0, d, n); chk("after_rst_data", d, 32'h21);
      send(1, 8'h57, 1, 1, 0);
      rd(1, 1, d, n); chk("perr_status", d, 32'h9);
      rd(1, 0, d, n); chk("perr_data", d, 32'h57);
      wr(1, 1, 4'h1, 32'h8);
      send(1, 8'h57, 1, 1, 1);
      rd(1, 1, d, n); chk("par_ok_status", d, 32'h1);
      rd(1, 0, d, n); chk("par_ok_data", d, 32'h57);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter AAW, default 1: Avalon MM address width.
REQ-002 SHALL have parameter ADW, default 32: Avalon MM data width; ABW = ADW/8 byteenable width.
REQ-003 SHALL have parameter BYTESIZE, default 8: data bits per frame, range 5..8.
REQ-004 SHALL have parameter PARITY, default "NONE": one of "NONE", "ODD", "EVEN".
REQ-005 SHALL have parameter STOPSIZE, default 1: stop bits checked per frame, 1 or 2.
REQ-006 SHALL have parameter N_BIT, default 16: clk cycles per bit (FRQ/BAUDRATE), even, minimum 4.
REQ-007 SHALL have port clk, input, 1: system clock.
REQ-008 SHALL have port rst, input, 1: reset; asynchronous, active-high.
REQ-009 SHALL have port avalon_read, input, 1: read request.
REQ-010 SHALL have port avalon_write, input, 1: write request.
REQ-011 SHALL have port avalon_address, input, AAW: register address.
REQ-012 SHALL have port avalon_byteenable, input, ABW: byte enables.
REQ-013 SHALL have port avalon_writedata, input, ADW: write data.
REQ-014 SHALL have port avalon_readdata, output, ADW: read data.
REQ-015 SHALL have port avalon_waitrequest, output, 1: stall current transfer.
REQ-016 SHALL have port uart_rxd, input, 1: asynchronous serial input, idle high.

Function
REQ-017 SHALL pass uart_rxd through a 2-flop synchronizer reset to 1; all detection uses the synchronized value.
REQ-018 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY="NONE".
REQ-019 In IDLE, SHALL enter START on a synchronized 1->0 transition and load the bit counter with N_BIT/2-1.
REQ-020 In START, at counter expiry (mid start bit), SHALL return to IDLE if the line is 1 (false start), else enter DATA with counter N_BIT-1.
REQ-021 In DATA, SHALL sample once per N_BIT cycles at mid bit, LSB first, BYTESIZE bits, then go to PARITY or STOP.
REQ-022 In PARITY, SHALL set perr_flag when the sample mismatches the parity (ODD: ~^data; EVEN: ^data).
REQ-023 In STOP, SHALL sample STOPSIZE bits; any 0 sets ferr_flag; after the last stop sample, SHALL load the holding register and return to IDLE in the same cycle; the next start edge is accepted immediately.
REQ-024 On load, SHALL set rx_valid; if rx_valid is already set and no pop occurs that cycle, the new byte overwrites and ovr_flag sets.
REQ-025 On simultaneous pop and load, SHALL return the old byte, hold the new byte, keep rx_valid=1 and leave ovr_flag unchanged.
REQ-026 Address 0 read SHALL return data in [BYTESIZE-1:0], zeros above, and pop (clear rx_valid) on the transfer cycle.
REQ-027 avalon_waitrequest SHALL equal avalon_read & (address==0) & ~rx_valid, combinationally; all other accesses complete with zero wait states.
REQ-028 Address 1 read SHALL return {0..., busy[4], perr[3], ferr[2], ovr[1], rx_valid[0]} without side effects; busy = FSM not in IDLE.
REQ-029 Address 1 write with byteenable[0]=1 SHALL clear each of bits [3:1] written as 1 (W1C); writes to address 0 are ignored.
REQ-030 avalon_readdata SHALL be combinational and valid on the transfer cycle; it is 0 when no read is active.

Reset
REQ-031 While rst=1: FSM IDLE, counters 0, holding register 0, rx_valid/ovr/perr/ferr 0, synchronizer 1, avalon_readdata 0.
REQ-032 rst asserted mid-frame SHALL discard the partial byte with no flag set; a pending address 0 read sees waitrequest=1.

Structure
REQ-033 Register addresses (0 data, 1 status) and status bit positions SHALL be constants in the shared package uart_pkg, also used by the transmitter.
REQ-034 The synchronizer SHALL be a sub-module uart_sync (parameter stages=2, reset value 1); all else is flat.

Verification
REQ-035 N_BIT=4, frame 0x48 ("H") 8N1 -> address 0 read returns 0x00000048; status then reads 0x0.
REQ-036 Address 0 read issued before any frame -> waitrequest stays 1 until the stop-bit sample of 0x65 ("e"), then returns 0x65 in that transfer.
REQ-037 Two frames 0x6C, 0x6F with no read between -> status 0x3; address 0 returns 0x6F; W1C write 0x2 -> status 0x0.
REQ-038 Frame with stop bit 0 -> status bit 2 set, byte still loaded; a 2-clock-low glitch in IDLE -> no load, busy returns to 0.
REQ-039 PARITY="EVEN", frame 0x57 with parity bit 0 -> status 0x9 (perr+valid); correct parity 1 -> status 0x1.
REQ-040 rst pulse during DATA of 0x21 -> status 0x0, no byte; next frame 0x21 received correctly.
